// File: rtl/instruction_fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module      : instruction_fetch_unit_if
// Description : Fetch-side bus bundle. It carries the instruction memory
//               request/response (PC/Inst), the decode control inputs
//               (stall/redirect) and the IF/ID slot presented to decode.
//               master = fetch unit, slave = memory + decode side.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface instruction_fetch_unit_if;
    logic [31:0] PC;
    logic [31:0] Inst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;

    modport master (
        output PC,
        input  Inst,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output id_inst,
        output id_pc,
        output id_pc_plus4,
        output id_valid
    );

    modport slave (
        input  PC,
        output Inst,
        output stall,
        output redirect,
        output redirect_pc,
        input  id_inst,
        input  id_pc,
        input  id_pc_plus4,
        input  id_valid
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : instruction_fetch_unit
// Description : Fetch initiator for a registered (1-cycle latency) instruction
//               memory. It owns the PC, pairs each returned word with its
//               address and presents the IF/ID slot. It supports stall through
//               a 1-entry skid register and redirect with a one-bubble squash.
//               Optional macro FETCH_PERF_CNT_EN adds the fetch and squash
//               performance counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 32
) (
    input  wire logic              clock,
    input  wire logic              reset,
    instruction_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [31:0]            squash_count
`endif
);

    // Byte span of the instruction memory; every PC value wraps modulo this.
    localparam logic [31:0] c_PC_SPAN = 32'(IMEM_WORDS * 4);

    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_req_valid;
    logic [31:0] r_skid_inst;
    logic        r_skid_valid;

    logic [31:0] w_pc_seq;
    logic [31:0] w_redirect_aligned;
    logic [31:0] w_redirect_target;

    // Next sequential address and word-aligned, wrapped redirect target.
    always_comb begin
        w_pc_seq           = (r_pc + 32'd4) % c_PC_SPAN;
        w_redirect_aligned = bus.redirect_pc & ~32'd3;
        w_redirect_target  = w_redirect_aligned % c_PC_SPAN;
    end

    // PC, request tracking and skid capture; priority reset > redirect > stall > advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc         <= RESET_PC;
            r_req_pc     <= 32'd0;
            r_req_valid  <= 1'b0;
            r_skid_inst  <= 32'd0;
            r_skid_valid <= 1'b0;
        end else if (bus.redirect) begin
            // The word the memory returns after this edge is wrong-path.
            r_pc         <= w_redirect_target;
            r_req_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (bus.stall) begin
            // Memory re-reads pc_q while stalled, so keep the slot's word here.
            if (r_req_valid && !r_skid_valid) begin
                r_skid_inst  <= bus.Inst;
                r_skid_valid <= 1'b1;
            end
        end else begin
            r_pc         <= w_pc_seq;
            r_req_pc     <= r_pc;
            r_req_valid  <= 1'b1;
            r_skid_valid <= 1'b0;
        end
    end

    assign bus.PC          = r_pc;
    assign bus.id_inst     = r_skid_valid ? r_skid_inst : bus.Inst;
    assign bus.id_pc       = r_req_pc;
    assign bus.id_pc_plus4 = (r_req_pc + 32'd4) % c_PC_SPAN;
    assign bus.id_valid    = r_req_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_squash_count;

    // Saturating counts of accepted fetches and squashed in-flight fetches.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_count  <= 32'd0;
            r_squash_count <= 32'd0;
        end else begin
            if (r_req_valid && !bus.stall && !bus.redirect && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (bus.redirect && r_req_valid && (r_squash_count != 32'hFFFF_FFFF)) begin
                r_squash_count <= r_squash_count + 32'd1;
            end
        end
    end

    assign fetch_count  = r_fetch_count;
    assign squash_count = r_squash_count;
`endif

endmodule

`default_nettype wire
